// File: rtl/lsu_mem_if.sv
// ------------------------------------------------------------------
// lsu_mem_if : RV32 load/store initiator to a word-organised memory
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lsu_mem_if #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid_i,
    output logic        core_ready_o,
    input  logic        core_we_i,
    input  logic [2:0]  core_funct3_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [29:0]   waddr_q;
    logic [1:0]    off_q;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic [7:0]    lanes_q;
    logic [63:0]   wdata_q;
    logic [31:0]   rdata0_q, rdata1_q;
    logic [TW-1:0] tmo_q;

    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q;

    logic          w_accept, w_legal, w_cross_in, w_split, w_tmo, w_err, w_cap0, w_cap1;
    logic [3:0]    w_mask_in;
    logic [7:0]    w_lanes_in, w_lanes_nx;
    logic [63:0]   w_wdata_in, w_wdata_nx;
    logic [29:0]   w_waddr_nx;
    logic          w_we_nx;
    logic [31:0]   w_rd0, w_rd1, w_ld_raw, w_ld_ext;

    // Request decode straight from the core inputs, used on the accept cycle
    always_comb begin
        case (core_funct3_i[1:0])
            2'b00:   w_mask_in = 4'b0001;
            2'b01:   w_mask_in = 4'b0011;
            default: w_mask_in = 4'b1111;
        endcase
        case (core_funct3_i)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !core_we_i;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_lanes_in = {4'b0000, w_mask_in} << core_addr_i[1:0];
    assign w_wdata_in = {32'h0, core_wdata_i} << {core_addr_i[1:0], 3'b000};
    assign w_cross_in = |w_lanes_in[7:4];
    assign w_split    = |lanes_q[7:4];
    assign w_accept   = core_valid_i && (state_q == IDLE);
    assign w_tmo      = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    assign w_lanes_nx = w_accept ? w_lanes_in : lanes_q;
    assign w_wdata_nx = w_accept ? w_wdata_in : wdata_q;
    assign w_waddr_nx = w_accept ? core_addr_i[31:2] : waddr_q;
    assign w_we_nx    = w_accept ? core_we_i : we_q;

    always_comb begin
        state_d = state_q;
        w_err   = 1'b0;
        w_cap0  = 1'b0;
        w_cap1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_valid_i) begin
                    if (!w_legal || (w_cross_in && !ALLOW_MISALIGNED)) begin
                        state_d = DONE;
                        w_err   = 1'b1;
                    end else begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0, WAIT0: begin
                if (mem_rvalid_i && (mem_gnt_i || state_q == WAIT0)) begin
                    w_cap0  = 1'b1;
                    state_d = w_split ? REQ1 : DONE;
                end else if (mem_gnt_i && state_q == REQ0) begin
                    state_d = WAIT0;
                end else if (w_tmo) begin
                    state_d = DONE;
                    w_err   = 1'b1;
                end
            end
            REQ1, WAIT1: begin
                if (mem_rvalid_i && (mem_gnt_i || state_q == WAIT1)) begin
                    w_cap1  = 1'b1;
                    state_d = DONE;
                end else if (mem_gnt_i && state_q == REQ1) begin
                    state_d = WAIT1;
                end else if (w_tmo) begin
                    state_d = DONE;
                    w_err   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load merge: data arriving this cycle bypasses the capture buffers
    assign w_rd0    = w_cap0 ? mem_rdata_i : rdata0_q;
    assign w_rd1    = w_cap1 ? mem_rdata_i : rdata1_q;
    assign w_ld_raw = 32'({w_rd1, w_rd0} >> {off_q, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  w_ld_ext = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            3'b001:  w_ld_ext = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            3'b100:  w_ld_ext = {24'h0, w_ld_raw[7:0]};
            3'b101:  w_ld_ext = {16'h0, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
    end

    always_comb begin
        resp_rdata_d = resp_rdata_q;
        if (state_d == DONE) begin
            resp_rdata_d = (w_err || we_q) ? 32'h0 : w_ld_ext;
        end
    end

    // Memory outputs follow the state being entered so they are registered
    always_comb begin
        mem_req_d   = (state_d == REQ0) || (state_d == REQ1);
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
        mem_wdata_d = 32'h0;
        if (state_d == REQ0) begin
            mem_addr_d  = {w_waddr_nx, 2'b00};
            mem_we_d    = w_we_nx;
            mem_be_d    = w_lanes_nx[3:0];
            mem_wdata_d = w_wdata_nx[31:0];
        end else if (state_d == REQ1) begin
            mem_addr_d  = {w_waddr_nx, 2'b00} + 32'd4;
            mem_we_d    = w_we_nx;
            mem_be_d    = w_lanes_nx[7:4];
            mem_wdata_d = w_wdata_nx[63:32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            lanes_q      <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            tmo_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                waddr_q  <= core_addr_i[31:2];
                off_q    <= core_addr_i[1:0];
                funct3_q <= core_funct3_i;
                we_q     <= core_we_i;
                lanes_q  <= w_lanes_in;
                wdata_q  <= w_wdata_in;
            end
            if (w_cap0) rdata0_q <= mem_rdata_i;
            if (w_cap1) rdata1_q <= mem_rdata_i;
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (state_q inside {REQ0, WAIT0, REQ1, WAIT1}) begin
                tmo_q <= tmo_q + TW'(1);
            end
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= (state_d == DONE);
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= (state_d == DONE) && w_err;
        end
    end

    assign core_ready_o = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
// ------------------------------------------------------------------
// tb_lsu_mem_if : directed self-checking bench for lsu_mem_if
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid_a, core_valid_b, core_we;
    logic [2:0]  core_f3;
    logic [31:0] core_addr, core_wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    logic        ready_a, rv_a, err_a, req_a, we_a;
    logic [31:0] rdata_a, addr_a, wdata_a;
    logic [3:0]  be_a;
    logic        ready_b, rv_b, err_b, req_b, we_b;
    logic [31:0] rdata_b, addr_b, wdata_b;
    logic [3:0]  be_b;

    always #5 clk = ~clk;

    lsu_mem_if #(.ALLOW_MISALIGNED(1'b1), .MEM_TIMEOUT(8)) u_dut (
        .clk(clk), .reset(reset),
        .core_valid_i(core_valid_a), .core_ready_o(ready_a), .core_we_i(core_we),
        .core_funct3_i(core_f3), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .resp_valid_o(rv_a), .resp_rdata_o(rdata_a), .resp_err_o(err_a),
        .mem_req_o(req_a), .mem_gnt_i(gnt), .mem_addr_o(addr_a), .mem_we_o(we_a),
        .mem_be_o(be_a), .mem_wdata_o(wdata_a), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
    );

    lsu_mem_if #(.ALLOW_MISALIGNED(1'b0), .MEM_TIMEOUT(8)) u_dut_na (
        .clk(clk), .reset(reset),
        .core_valid_i(core_valid_b), .core_ready_o(ready_b), .core_we_i(core_we),
        .core_funct3_i(core_f3), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .resp_valid_o(rv_b), .resp_rdata_o(rdata_b), .resp_err_o(err_b),
        .mem_req_o(req_b), .mem_gnt_i(1'b0), .mem_addr_o(addr_b), .mem_we_o(we_b),
        .mem_be_o(be_b), .mem_wdata_o(wdata_b), .mem_rvalid_i(1'b0), .mem_rdata_i(32'h0)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t       log_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          mode = 0;       // 0 none, 1 gnt+rvalid together, 2 gnt only, 3 rvalid a cycle after gnt
    int          req_cyc_a = 0;
    int          req_cyc_b = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: reacts to registered outputs at the falling edge
    initial begin
        logic        pend;
        logic [31:0] pend_data;
        pend = 1'b0;
        pend_data = 32'h0;
        gnt = 1'b0;
        rvalid = 1'b0;
        rdata = 32'h0;
        forever begin
            @(negedge clk);
            gnt = 1'b0;
            rvalid = 1'b0;
            rdata = 32'h0;
            if (pend) begin
                rvalid = 1'b1;
                rdata = pend_data;
                pend = 1'b0;
            end
            if (req_a) req_cyc_a++;
            if (req_b) req_cyc_b++;
            if (req_a && mode != 0) begin
                gnt = 1'b1;
                log_q.push_back('{addr: addr_a, be: be_a, we: we_a, wdata: wdata_a});
                if (mode == 1) begin
                    rvalid = 1'b1;
                    rdata = rd_word(addr_a);
                end else if (mode == 3) begin
                    pend = 1'b1;
                    pend_data = rd_word(addr_a);
                end
            end
        end
    end

    task automatic run_access(input bit sel_b, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output int lat);
        log_q.delete();
        core_we = we;
        core_f3 = f3;
        core_addr = addr;
        core_wdata = wd;
        if (sel_b) core_valid_b = 1'b1;
        else       core_valid_a = 1'b1;
        @(negedge clk);
        core_valid_a = 1'b0;
        core_valid_b = 1'b0;
        chk("busy_not_ready", 32'(sel_b ? ready_b : ready_a), 32'd0);
        lat = 1;
        while (!(sel_b ? rv_b : rv_a) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("resp_wait_expired", 32'd0, 32'd1);
        rd  = sel_b ? rdata_b : rdata_a;
        err = sel_b ? err_b : err_a;
        @(negedge clk);
        chk("resp_pulse_len", 32'(sel_b ? rv_b : rv_a), 32'd0);
    endtask

    task automatic chk_beat(input int idx, input string tag, input logic [31:0] a,
                            input logic [3:0] be, input logic we, input logic [31:0] wd);
        if (idx < log_q.size()) begin
            chk({tag, "_addr"}, log_q[idx].addr, a);
            chk({tag, "_be"}, 32'(log_q[idx].be), 32'(be));
            chk({tag, "_we"}, 32'(log_q[idx].we), 32'(we));
            chk({tag, "_wdata"}, log_q[idx].wdata, wd);
        end else begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        int          rc;
        int          seen;

        reset = 1'b1;
        core_valid_a = 1'b0;
        core_valid_b = 1'b0;
        core_we = 1'b0;
        core_f3 = 3'b000;
        core_addr = 32'h0;
        core_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_resp_valid", 32'(rv_a), 32'd0);
        chk("rst_mem_req", 32'(req_a), 32'd0);
        chk("rst_mem_addr", addr_a, 32'h0);
        chk("rst_mem_be", 32'(be_a), 32'd0);
        chk("rst_resp_rdata", rdata_a, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Aligned LW, minimum latency
        mem_model[32'h100] = 32'hDEADBEEF;
        mode = 1;
        run_access(0, 1'b0, 3'b010, 32'h100, 32'h0, r, e, lat);
        chk("lw_nbeats", 32'(log_q.size()), 32'd1);
        chk_beat(0, "lw_b0", 32'h100, 4'b1111, 1'b0, 32'h0);
        chk("lw_rdata", r, 32'hDEADBEEF);
        chk("lw_err", 32'(e), 32'd0);
        chk("lw_latency", 32'(lat), 32'd2);

        // LB / LBU at byte 3
        mem_model[32'h100] = 32'h80FF0000;
        run_access(0, 1'b0, 3'b000, 32'h103, 32'h0, r, e, lat);
        chk_beat(0, "lb_b0", 32'h100, 4'b1000, 1'b0, 32'h0);
        chk("lb_rdata", r, 32'hFFFFFF80);
        run_access(0, 1'b0, 3'b100, 32'h103, 32'h0, r, e, lat);
        chk("lbu_rdata", r, 32'h00000080);

        // SH at 0x102
        run_access(0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, r, e, lat);
        chk("sh_nbeats", 32'(log_q.size()), 32'd1);
        chk_beat(0, "sh_b0", 32'h100, 4'b1100, 1'b1, 32'hABCD0000);
        chk("sh_rdata", r, 32'h0);
        chk("sh_err", 32'(e), 32'd0);

        // Misaligned LW with delayed rvalid (through WAIT0/WAIT1)
        mem_model[32'h0FC] = 32'h11223344;
        mem_model[32'h100] = 32'h55667788;
        mode = 3;
        run_access(0, 1'b0, 3'b010, 32'h0FE, 32'h0, r, e, lat);
        chk("mlw_nbeats", 32'(log_q.size()), 32'd2);
        chk_beat(0, "mlw_b0", 32'h0FC, 4'b1100, 1'b0, 32'h0);
        chk_beat(1, "mlw_b1", 32'h100, 4'b0011, 1'b0, 32'h0);
        chk("mlw_rdata", r, 32'h77881122);
        chk("mlw_err", 32'(e), 32'd0);

        // Misaligned SW wrapping the address space
        mode = 1;
        run_access(0, 1'b1, 3'b010, 32'hFFFFFFFD, 32'hA1B2C3D4, r, e, lat);
        chk("msw_nbeats", 32'(log_q.size()), 32'd2);
        chk_beat(0, "msw_b0", 32'hFFFFFFFC, 4'b1110, 1'b1, 32'hB2C3D400);
        chk_beat(1, "msw_b1", 32'h00000000, 4'b0001, 1'b1, 32'h000000A1);

        // Crossing LH, both beats completing in their request cycles
        mem_model[32'h000] = 32'h12345678;
        mem_model[32'h004] = 32'h9ABCDEF0;
        run_access(0, 1'b0, 3'b001, 32'h003, 32'h0, r, e, lat);
        chk_beat(0, "mlh_b0", 32'h000, 4'b1000, 1'b0, 32'h0);
        chk_beat(1, "mlh_b1", 32'h004, 4'b0001, 1'b0, 32'h0);
        chk("mlh_rdata", r, 32'hFFFFF012);

        // Illegal funct3 and BU-store
        rc = req_cyc_a;
        run_access(0, 1'b0, 3'b011, 32'h100, 32'h0, r, e, lat);
        chk("f011_err", 32'(e), 32'd1);
        chk("f011_rdata", r, 32'h0);
        chk("f011_latency", 32'(lat), 32'd1);
        run_access(0, 1'b1, 3'b100, 32'h100, 32'h0, r, e, lat);
        chk("sbu_err", 32'(e), 32'd1);
        chk("illegal_no_req", 32'(req_cyc_a - rc), 32'd0);

        // Misalignment disallowed
        run_access(1, 1'b0, 3'b001, 32'h003, 32'h0, r, e, lat);
        chk("na_err", 32'(e), 32'd1);
        chk("na_rdata", r, 32'h0);
        chk("na_no_req", 32'(req_cyc_b), 32'd0);

        // Grant never arrives: abort after 8 request cycles
        mode = 0;
        rc = req_cyc_a;
        run_access(0, 1'b0, 3'b010, 32'h200, 32'h0, r, e, lat);
        chk("tmo_err", 32'(e), 32'd1);
        chk("tmo_rdata", r, 32'h0);
        chk("tmo_req_cycles", 32'(req_cyc_a - rc), 32'd8);
        chk("tmo_latency", 32'(lat), 32'd9);

        // Recovery, leaves a non-zero resp_rdata for the reset test
        mem_model[32'h100] = 32'hDEADBEEF;
        mode = 1;
        run_access(0, 1'b0, 3'b010, 32'h100, 32'h0, r, e, lat);
        chk("rec_rdata", r, 32'hDEADBEEF);
        chk("rec_err", 32'(e), 32'd0);

        // Asynchronous reset while waiting for the read response
        mode = 2;
        core_we = 1'b0;
        core_f3 = 3'b010;
        core_addr = 32'h100;
        core_valid_a = 1'b1;
        @(negedge clk);
        core_valid_a = 1'b0;
        chk("rstw_req_seen", 32'(req_a), 32'd1);
        @(negedge clk);
        chk("rstw_in_wait", 32'(req_a | ready_a), 32'd0);
        reset = 1'b1;
        #1;
        chk("rstw_ready", 32'(ready_a), 32'd1);
        chk("rstw_mem_req", 32'(req_a), 32'd0);
        chk("rstw_mem_addr", addr_a, 32'h0);
        chk("rstw_resp_rdata", rdata_a, 32'h0);
        chk("rstw_resp_valid", 32'(rv_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv_a || req_a) seen++;
        end
        chk("rstw_quiet", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
